// File: rtl/full_dm_rf_alu.sv
// Single-cycle register file + ALU + data memory slice; Zero is the only observable output.
// Optional macro FULL_DM_RF_ALU_SLT_EN enables signed set-less-than on FuncCode 1010.
module full_dm_rf_alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] SEin,
   input  logic [3:0]  FuncCode,
   input  logic        Regsel,
   input  logic        ALUsel,
   input  logic [1:0]  ALUOp,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic        MemToRegSel,
   input  logic        RegWrite,
   output logic        Zero
);

   localparam int DATA_W    = 32;
   localparam int REG_WORDS = 32;
   localparam int MEM_WORDS = 64;

   logic [DATA_W-1:0]        regs [REG_WORDS];
   logic [DATA_W-1:0]        mem  [MEM_WORDS];
   logic signed [DATA_W-1:0] imm_ext;
   logic signed [DATA_W-1:0] op_a;
   logic signed [DATA_W-1:0] op_b;
   logic signed [DATA_W-1:0] alu_result;
   logic [5:0]               mem_index;
   logic [DATA_W-1:0]        read_data;
   logic [DATA_W-1:0]        wb_data;
   logic [4:0]               wr_addr;

   function automatic logic signed [DATA_W-1:0] alu_func(
      input logic [1:0]               op,
      input logic [3:0]               fc,
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [DATA_W-1:0] res;
      res = '0;
      case (op)
         2'b00: res = a + b;
         2'b01: res = a - b;
         2'b11: res = a & b;
         default: begin
            case (fc)
               4'b0000: res = a + b;
               4'b0010: res = a - b;
               4'b0100: res = a & b;
               4'b0101: res = a | b;
`ifdef FULL_DM_RF_ALU_SLT_EN
               4'b1010: res = {{(DATA_W-1){1'b0}}, (a < b)};
`endif
               default: res = '0;
            endcase
         end
      endcase
      return res;
   endfunction

   always_comb begin
      imm_ext    = {{16{SEin[15]}}, SEin};
      op_a       = regs[rs];
      op_b       = ALUsel ? imm_ext : regs[rt];
      alu_result = alu_func(ALUOp, FuncCode, op_a, op_b);
      Zero       = (alu_result == '0);
      // Byte address wraps every 256 bytes; only the word index selects storage.
      mem_index  = alu_result[7:2];
      read_data  = MemRead ? mem[mem_index] : '0;
      wb_data    = MemToRegSel ? read_data : alu_result;
      wr_addr    = Regsel ? rd : rt;
   end

   // Both writes sample pre-edge values, so a same-address read in this cycle sees old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_WORDS; i++) regs[i] <= '0;
         for (int j = 0; j < MEM_WORDS; j++) mem[j] <= '0;
      end else begin
         if (RegWrite) regs[wr_addr] <= wb_data;
         if (MemWrite) mem[mem_index] <= regs[rt];
      end
   end

endmodule

// File: tb/tb_full_dm_rf_alu.sv
// Bench for full_dm_rf_alu: directed vector table, model-checked random traffic, async reset sequence.
module tb_full_dm_rf_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs, rt, rd;
   logic [15:0] SEin;
   logic [3:0]  FuncCode;
   logic        Regsel, ALUsel, MemWrite, MemRead, MemToRegSel, RegWrite;
   logic [1:0]  ALUOp;
   logic        Zero;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_reg [32];
   logic [31:0] m_mem [64];

   typedef struct {
      logic [4:0]  rs, rt, rd;
      logic [15:0] sein;
      logic [3:0]  fc;
      logic [1:0]  aluop;
      logic        alusel, regsel, mw, mr, m2r, rw;
      logic        zero;
   } vec_t;

   vec_t tbl[$];

   full_dm_rf_alu dut (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .SEin(SEin),
      .FuncCode(FuncCode), .Regsel(Regsel), .ALUsel(ALUsel), .ALUOp(ALUOp),
      .MemWrite(MemWrite), .MemRead(MemRead), .MemToRegSel(MemToRegSel),
      .RegWrite(RegWrite), .Zero(Zero)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [4:0] a_rs, a_rt, a_rd, input logic [15:0] a_sein,
                               input logic [3:0] a_fc, input logic [1:0] a_op,
                               input logic a_alusel, a_regsel, a_mw, a_mr, a_m2r, a_rw, a_zero);
      vec_t v;
      v.rs = a_rs; v.rt = a_rt; v.rd = a_rd; v.sein = a_sein; v.fc = a_fc; v.aluop = a_op;
      v.alusel = a_alusel; v.regsel = a_regsel; v.mw = a_mw; v.mr = a_mr; v.m2r = a_m2r;
      v.rw = a_rw; v.zero = a_zero;
      return v;
   endfunction

   // Reference ALU: plain integer arithmetic on the documented operations.
   function automatic logic [31:0] model_alu(input vec_t v);
      longint a, b, r;
      a = longint'($signed(m_reg[v.rs]));
      b = v.alusel ? longint'($signed(v.sein)) : longint'($signed(m_reg[v.rt]));
      r = 0;
      if (v.aluop == 2'b00 || (v.aluop == 2'b10 && v.fc == 4'b0000)) r = a + b;
      else if (v.aluop == 2'b01 || (v.aluop == 2'b10 && v.fc == 4'b0010)) r = a - b;
      else if (v.aluop == 2'b11 || (v.aluop == 2'b10 && v.fc == 4'b0100)) r = a & b;
      else if (v.aluop == 2'b10 && v.fc == 4'b0101) r = a | b;
`ifdef FULL_DM_RF_ALU_SLT_EN
      else if (v.aluop == 2'b10 && v.fc == 4'b1010) r = (a < b) ? 1 : 0;
`endif
      return r[31:0];
   endfunction

   function automatic void model_commit(input vec_t v);
      logic [31:0] res, rdata, store;
      res   = model_alu(v);
      rdata = v.mr ? m_mem[res[7:2]] : 32'h0;
      store = m_reg[v.rt];
      if (v.rw) m_reg[v.regsel ? v.rd : v.rt] = v.m2r ? rdata : res;
      if (v.mw) m_mem[res[7:2]] = store;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
   endfunction

   task automatic check(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: Zero=%b, expected %b", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rs = v.rs; rt = v.rt; rd = v.rd; SEin = v.sein; FuncCode = v.fc; ALUOp = v.aluop;
      ALUsel = v.alusel; Regsel = v.regsel; MemWrite = v.mw; MemRead = v.mr;
      MemToRegSel = v.m2r; RegWrite = v.rw;
   endtask

   // Called one time unit after a rising edge; checks mid-cycle, then crosses the next edge.
   task automatic apply(input vec_t v, input string name, input bit use_table);
      logic exp;
      drive(v);
      #1;
      exp = use_table ? v.zero : (model_alu(v) == 32'h0);
      check(name, Zero, exp);
      @(posedge clk);
      if (!rst) model_commit(v);
      #1;
   endtask

   initial begin
      vec_t v;
      logic slt_zero;
      logic [31:0] neg;
`ifdef FULL_DM_RF_ALU_SLT_EN
      slt_zero = 1'b0;
`else
      slt_zero = 1'b1;
`endif
      //           rs rt rd sein      fc       op sel rsel mw mr m2r rw zero
      tbl.push_back(mk(0, 0, 1, 16'h0014, 4'h0,    0, 1, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 16'h0028, 4'h0,    0, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2, 16'h0028, 4'h0,    0, 1, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk(1, 2, 0, 16'h0000, 4'b0010, 2, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2, 0, 16'h0000, 4'b0101, 2, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, 16'h0014, 4'h0,    1, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 16'hFFEC, 4'h0,    0, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 3, 16'h0005, 4'h0,    0, 1, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 4, 16'hFFFF, 4'h0,    0, 1, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(3, 4, 0, 16'h0000, 4'b1010, 2, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4, 3, 0, 16'h0000, 4'b1010, 2, 0, 0, 0, 0, 0, 0, slt_zero));
      tbl.push_back(mk(4, 3, 0, 16'h0000, 4'b0001, 2, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4, 3, 0, 16'h0000, 4'h0,    3, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 3, 0, 16'h0000, 4'b0100, 2, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 0, 0, 16'h0001, 4'b0000, 2, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 5, 16'h0000, 4'h0,    0, 1, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 5, 16'h0000, 4'h0,    0, 1, 1, 0, 0, 1, 1, 0));
      tbl.push_back(mk(5, 0, 0, 16'h0000, 4'h0,    0, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 6, 7, 16'h0000, 4'h0,    0, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(6, 0, 0, 16'h0014, 4'h0,    1, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(7, 0, 0, 16'h0000, 4'h0,    0, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 3, 0, 16'h012B, 4'h0,    0, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8, 16'h0028, 4'h0,    0, 1, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk(8, 0, 0, 16'h0005, 4'h0,    1, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 16'h0028, 4'h0,    0, 1, 0, 1, 0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 16'h0028, 4'h0,    1, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 9, 16'h0028, 4'h0,    0, 1, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk(9, 0, 0, 16'h0014, 4'h0,    1, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 16'h0007, 4'h0,    0, 1, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0007, 4'h0,    1, 1, 0, 0, 0, 0, 0, 1));

      rst = 1'b1;
      drive(mk(0, 0, 0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
      #3;
      check("reset_zero", Zero, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i), 1'b1);

      for (int i = 0; i < 400; i++) begin
         v.rs = 5'($urandom_range(0, 7)); v.rt = 5'($urandom_range(0, 7));
         v.rd = 5'($urandom_range(0, 7));
         v.aluop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: v.fc = 4'b0000; 1: v.fc = 4'b0010; 2: v.fc = 4'b0100;
            3: v.fc = 4'b0101; 4: v.fc = 4'b1010; default: v.fc = 4'($urandom);
         endcase
         v.alusel = 1'($urandom); v.regsel = 1'($urandom);
         v.mw = 1'($urandom); v.mr = 1'($urandom); v.m2r = 1'($urandom); v.rw = 1'($urandom);
         neg = 32'h0 - m_reg[v.rs];
         case ($urandom_range(0, 3))
            0: v.sein = neg[15:0];
            1: v.sein = 16'($urandom_range(0, 255));
            default: v.sein = 16'($urandom);
         endcase
         v.zero = 1'b0;
         apply(v, $sformatf("rand%0d", i), 1'b0);
      end

      apply(mk(0, 0, 0, 16'h0000, 4'h0, 3, 1, 1, 0, 0, 0, 1, 1), "rs_clr_r0", 1'b1);
      apply(mk(0, 0, 1, 16'h0014, 4'h0, 0, 1, 1, 0, 0, 0, 1, 0), "rs_set_r1", 1'b1);
      apply(mk(0, 1, 0, 16'h0028, 4'h0, 0, 1, 0, 1, 0, 0, 0, 0), "rs_set_m10", 1'b1);
      drive(mk(1, 0, 0, 16'h0014, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0));
      #1;
      check("rs_pre_r1", Zero, 1'b1);
      rst = 1'b1;
      model_reset();
      drive(mk(1, 0, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0));
      #1;
      check("rs_async_r1", Zero, 1'b1);
      drive(mk(0, 1, 1, 16'h0033, 4'h0, 0, 1, 1, 1, 0, 0, 1, 0));
      @(posedge clk); #1;
      drive(mk(1, 0, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0));
      #1;
      check("rs_blocked_r1", Zero, 1'b1);
      rst = 1'b0;
      apply(mk(0, 0, 2, 16'h0055, 4'h0, 0, 1, 1, 0, 0, 0, 1, 0), "rs_set_r2", 1'b1);
      apply(mk(2, 0, 0, 16'h0055, 4'h0, 1, 1, 0, 0, 0, 0, 0, 1), "rs_first_wr", 1'b1);
      apply(mk(0, 0, 2, 16'h0028, 4'h0, 0, 1, 1, 0, 1, 1, 1, 0), "rs_load_m10", 1'b1);
      apply(mk(2, 0, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1), "rs_m10_clear", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
